// File: rtl/buffer_wr_arbiter_if.sv
// Write-side bundle between the producers/FIFO (master) and buffer_wr_arbiter (slave).
interface buffer_wr_arbiter_if #(
  parameter int unsigned bit_width = 16,
  parameter int unsigned n_req     = 4
);
  logic [n_req-1:0]           req;
  logic [n_req*bit_width-1:0] req_data;
  logic                       full;
  logic [n_req-1:0]           gnt;
  logic                       load;
  logic [bit_width-1:0]       data_out;
  logic                       busy;

  modport master (output req, req_data, full, input gnt, load, data_out, busy);
  modport slave  (input req, req_data, full, output gnt, load, data_out, busy);
endinterface

// File: rtl/buffer_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among n_req producers.
// Define BUF_ARB_FIXED_PRIO_EN to select lowest-index fixed priority instead of round-robin.
module buffer_wr_arbiter #(
  parameter int unsigned bit_width = 16,
  parameter int unsigned n_req     = 4,
  parameter int unsigned burst_len = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  buffer_wr_arbiter_if.slave bus
);
  localparam int unsigned IW = (n_req > 1) ? $clog2(n_req) : 1;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(burst_len - 1);
  localparam logic [n_req-1:0] GNT_ONE = {{(n_req-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] own_q, own_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] win_c;
  logic          busy_c, req_own_c, acc_c;

`ifdef BUF_ARB_FIXED_PRIO_EN
  // Lowest set index wins; scanning downward leaves the lowest one last.
  always_comb begin
    win_c = '0;
    for (int i = int'(n_req) - 1; i >= 0; i--) begin
      if (bus.req[IW'(i)]) win_c = IW'(i);
    end
  end
`else
  // First set request found searching upward from last+1, wrapping at n_req.
  always_comb begin
    int unsigned idx;
    logic        found;
    win_c = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= n_req; i++) begin
      idx = (32'(last_q) + i) % n_req;
      if (!found && bus.req[IW'(idx)]) begin
        win_c = IW'(idx);
        found = 1'b1;
      end
    end
  end
`endif

  assign busy_c    = (state_q == GRANT);
  assign req_own_c = bus.req[own_q];
  assign acc_c     = busy_c & req_own_c & ~bus.full;

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          own_d   = win_c;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A dropped request releases even while full; full alone only stalls.
        if (!req_own_c) begin
          last_d  = own_q;
          state_d = IDLE;
        end else if (!bus.full) begin
          if (cnt_q == CNT_LAST) begin
            last_d  = own_q;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      own_q   <= '0;
      last_q  <= IW'(n_req - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy     = busy_c;
  assign bus.load     = acc_c;
  assign bus.gnt      = acc_c ? (GNT_ONE << own_q) : '0;
  assign bus.data_out = busy_c ? bus.req_data[32'(own_q)*bit_width +: bit_width] : '0;

endmodule

// File: doc/buffer_wr_arbiter.md
# buffer_wr_arbiter

Round-robin write-port arbiter sharing one `buffer` FIFO write side among `n_req` producers. Each producer raises a request and presents a word. The arbiter grants one owner at a time for a bounded burst, drives the FIFO `load`/`data_in`, and stalls the owner while the FIFO reports `full`. It sits between the producer stages and the FIFO write port, in the FIFO write-clock domain.

## Interface
- `bit_width`, 16, word width; matches the FIFO `bit_width`.
- `n_req`, 4, number of producers, 2..16.
- `burst_len`, 4, maximum words per grant, 1..255.

- `clk`  in  1  FIFO write clock; all state on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  n_req  per-producer request; level, held while a word is presented.
- `req_data`  in  n_req*bit_width  producer words; producer i occupies bits [i*bit_width +: bit_width].
- `full`  in  1  FIFO full flag.
- `gnt`  out  n_req  one-hot; bit i high means producer i's word is written this cycle.
- `load`  out  1  FIFO write strobe.
- `data_out`  out  bit_width  word to FIFO `data_in`.
- `busy`  out  1  high in GRANT state.

## Operation
- States:
  - IDLE: no owner.
  - GRANT: owner register `own` valid.
- Registers: `own` (clog2(n_req) bits), `last` (last released owner), `cnt` (8-bit burst counter), `state`.
- IDLE: if `req` is non-zero, choose the winner by round-robin. Search indices `last+1, last+2, …` modulo `n_req`; the first set bit wins.
  - Next edge: `own` = winner, `cnt` = 0, state = GRANT.
  - If `req` is zero, stay in IDLE.
- GRANT, accept condition: `acc = req[own] & ~full`.
  - `load = acc`.
  - `gnt = acc << own`.
  - `data_out = req_data[own]` whenever in GRANT; 0 in IDLE.
- GRANT, on `acc`:
  - If `cnt == burst_len-1`: release. `last` = `own`, state = IDLE.
  - Otherwise: `cnt` = `cnt+1`.
- GRANT, `req[own]` low: release immediately (`last` = `own`, state = IDLE, no write).
- GRANT, `full` high with `req[own]` high: hold.
  - `load` = 0, `gnt` = 0.
  - `cnt`, `own` and state unchanged.
  - Ownership is never revoked by `full`.
- Requests from non-owners are ignored until release.
- Release always passes through IDLE, giving one bubble cycle between owners. This bubble is required; tests check it.
- `gnt`, `load` and `busy` are combinational from registered state plus `req`/`full`. There are no combinational paths from `req_data` to control outputs.

## Timing
- Reset (asynchronous assert on `rst_n` low, synchronous release on the first edge with `rst_n` high):
  - state = IDLE, `own` = 0, `cnt` = 0, `last` = n_req-1, so producer 0 wins first.
  - `gnt` = 0, `load` = 0, `data_out` = 0, `busy` = 0.
- Reset mid-burst: the write in progress is dropped and outputs fall immediately. After release, arbitration restarts from producer 0.
- Latency: `req` sampled high at edge k gives the first `load` during cycle k+1, when `full` is low.
- Throughput per burst: `burst_len` words in `burst_len` cycles with no full, then 1 idle cycle.
- Wrap-around: the round-robin search wraps from index n_req-1 to 0. `cnt` never exceeds burst_len-1.
- Simultaneous events:
  - `full` and release by `req[own]` low in the same cycle: release wins.
  - `acc` on the final burst word: the word is written and the grant released at the same edge.

## Configuration
- `BUF_ARB_FIXED_PRIO_EN` defined: IDLE picks the lowest-indexed set `req` bit. `last` is still updated but unused. Burst limit and bubble are unchanged, so a low index can starve higher ones only across bursts.
- Not defined: round-robin as described above.

## Test plan
- Reset release: `req`=4'b1111, `full`=0, `burst_len`=4.
  - `gnt` sequence is 0001×4, bubble, 0010×4, bubble, 0100×4, bubble, 1000×4, bubble, then 0001 again.
  - `data_out` equals the owner's word on every `load`.
- Backpressure: single `req[2]`, `full` high for 3 cycles after the 2nd word.
  - `load` = 0 for exactly those 3 cycles.
  - Words 3 and 4 are written after `full` falls.
  - Exactly 4 loads in the burst.
- Early drop: `req[1]` falls after 2 accepted words.
  - Release with no third load.
  - Next grant goes to the next requester after index 1.
- Mid-burst reset: pulse `rst_n` low during producer 3's 2nd word.
  - `load` and `gnt` drop asynchronously.
  - After release with `req`=4'b1001, producer 0 is granted first.
- `burst_len`=1, `req`=4'b0101: grants alternate 0001, bubble, 0100, bubble, one word each.
- With `BUF_ARB_FIXED_PRIO_EN`, `req`=4'b0110 held: every grant after each bubble goes to producer 1.
